// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: sequences per-domain active-low resets after clock lock.
// Waits for PLL_LOCKED, holds all resets for HOLD_CYCLES, then releases the
// domains one by one in ascending order, GAP_CYCLES apart. Lock loss or a
// software request re-asserts every domain reset.
// Optional: define RST_SEQ_EVENT_CNT_EN to add the saturating EVENT_CNT output.
module rst_seq_ctrl #(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PLL_LOCKED,
  input  logic                   SW_RST_REQ,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   RST_DONE,
  output logic                   BUSY
`ifdef RST_SEQ_EVENT_CNT_EN
  ,
  output logic [7:0]             EVENT_CNT
`endif
);

  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_HOLD      = 2'd1;
  localparam logic [1:0] S_RELEASE   = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic [NUM_DOMAINS-1:0] rst_n_nxt;
  logic                   done_nxt;
  logic                   busy_nxt;
  logic                   active;

  // Next-state and next-output logic; lock loss has priority over the software request
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rst_n_nxt = DOMAIN_RST_N;
    done_nxt  = 1'b0;
    active    = (state != S_WAIT_LOCK);

    if (active && !PLL_LOCKED) begin
      state_nxt = S_WAIT_LOCK;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      rst_n_nxt = '0;
    end else if (active && SW_RST_REQ) begin
      // Reloaded every cycle the request is held, so the hold starts once it drops
      state_nxt = S_HOLD;
      cnt_nxt   = HOLD_LOAD;
      idx_nxt   = '0;
      rst_n_nxt = '0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          if (PLL_LOCKED) begin
            state_nxt = S_HOLD;
            cnt_nxt   = HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            rst_n_nxt[0] = 1'b1;
            idx_nxt      = IDX_W'(1);
            cnt_nxt      = GAP_LOAD;
            state_nxt    = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;
          end else begin
            cnt_nxt = cnt - CNT_WIDTH'(1);
          end
        end
        S_RELEASE: begin
          if (cnt == '0) begin
            rst_n_nxt[idx] = 1'b1;
            if (idx == LAST_IDX) begin
              state_nxt = S_RUN;
            end else begin
              idx_nxt = idx + IDX_W'(1);
              cnt_nxt = GAP_LOAD;
            end
          end else begin
            cnt_nxt = cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          done_nxt = 1'b1;
        end
      endcase
    end

    busy_nxt = (state_nxt == S_HOLD) || (state_nxt == S_RELEASE);
  end

  // State, counter, index and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_WAIT_LOCK;
      cnt          <= '0;
      idx          <= '0;
      DOMAIN_RST_N <= '0;
      RST_DONE     <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      DOMAIN_RST_N <= rst_n_nxt;
      RST_DONE     <= done_nxt;
      BUSY         <= busy_nxt;
    end
  end

`ifdef RST_SEQ_EVENT_CNT_EN
  logic sw_seen;
  logic event_hit;

  // A re-assert event: lock loss, or the first accepted cycle of a software request
  always_comb begin
    event_hit = active && (!PLL_LOCKED || (SW_RST_REQ && !sw_seen));
  end

  // Saturating re-assert event counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sw_seen   <= 1'b0;
      EVENT_CNT <= '0;
    end else begin
      sw_seen <= active && PLL_LOCKED && SW_RST_REQ;
      if (event_hit && (EVENT_CNT != 8'hFF)) begin
        EVENT_CNT <= EVENT_CNT + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a timeline reference model pushes the
// expected outputs after every clock edge (or async reset), a monitor pops
// and compares them on the falling edge.
module tb_rst_seq_ctrl;

  localparam int unsigned N        = 3;
  localparam int unsigned CW       = 8;
  localparam int unsigned HOLD     = 16;
  localparam int unsigned GAP      = 4;
  localparam int unsigned LAST_REL = HOLD + (N - 1) * GAP;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         PLL_LOCKED = 1'b0;
  logic         SW_RST_REQ = 1'b0;
  logic [N-1:0] DOMAIN_RST_N;
  logic         RST_DONE;
  logic         BUSY;
`ifdef RST_SEQ_EVENT_CNT_EN
  logic [7:0]   EVENT_CNT;
`endif

  rst_seq_ctrl #(
    .NUM_DOMAINS(N),
    .CNT_WIDTH  (CW),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PLL_LOCKED  (PLL_LOCKED),
    .SW_RST_REQ  (SW_RST_REQ),
    .DOMAIN_RST_N(DOMAIN_RST_N),
    .RST_DONE    (RST_DONE),
    .BUSY        (BUSY)
`ifdef RST_SEQ_EVENT_CNT_EN
    ,
    .EVENT_CNT   (EVENT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0] dom;
    logic         done;
    logic         busy;
    logic [7:0]   evt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   started  = 1'b0;

  // Reference model: a sequence is "active" after lock is seen; m_t counts
  // edges since the sequence (re)started. Domain k is out of reset once
  // m_t >= HOLD + k*GAP; done one edge after the last release.
  bit          m_active = 1'b0;
  int unsigned m_t      = 0;
  int unsigned m_evt    = 0;
  bit          m_acc    = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    e.dom = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (m_active && (m_t >= HOLD + k * GAP)) e.dom[k] = 1'b1;
    end
    e.done = m_active && (m_t >= LAST_REL + 1);
    e.busy = m_active && (m_t < LAST_REL);
    e.evt  = 8'(m_evt);
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        m_active = 1'b0;
        m_t      = 0;
        m_evt    = 0;
        m_acc    = 1'b0;
        exp_q.delete();
      end else begin
        if (m_active && (!PLL_LOCKED || (SW_RST_REQ && !m_acc)) && (m_evt < 255))
          m_evt = m_evt + 1;
        m_acc = m_active && PLL_LOCKED && SW_RST_REQ;
        if (!m_active) begin
          if (PLL_LOCKED) begin
            m_active = 1'b1;
            m_t      = 0;
          end
        end else if (!PLL_LOCKED) begin
          m_active = 1'b0;
          m_t      = 0;
        end else if (SW_RST_REQ) begin
          m_t = 0;
        end else if (m_t < 1000) begin
          m_t = m_t + 1;
        end
      end
      exp_q.push_back(model_out());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (started && (exp_q.size() > 0)) begin
        e = exp_q.pop_front();
        chk("domain_rst_n", 32'(DOMAIN_RST_N), 32'(e.dom));
        chk("rst_done",     32'(RST_DONE),     32'(e.done));
        chk("busy",         32'(BUSY),         32'(e.busy));
`ifdef RST_SEQ_EVENT_CNT_EN
        chk("event_cnt",    32'(EVENT_CNT),    32'(e.evt));
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic async_reset_pulse();
    @(posedge CLK);
    #3 RST = 1'b0;
    step(2);
    RST = 1'b1;
  endtask

  initial begin
    #1 started = 1'b1;
    // Power-up
    step(5);
    RST = 1'b1;
    step(3);
    PLL_LOCKED = 1'b1;
    step(30);
    // Late lock after a fresh reset
    RST = 1'b0;
    step(3);
    PLL_LOCKED = 1'b0;
    RST = 1'b1;
    step(50);
    PLL_LOCKED = 1'b1;
    // Lock loss with bits 0,1 released, then relock
    step(22);
    PLL_LOCKED = 1'b0;
    step(3);
    PLL_LOCKED = 1'b1;
    step(30);
    // Software request in RUN, held 3 cycles
    SW_RST_REQ = 1'b1;
    step(3);
    SW_RST_REQ = 1'b0;
    step(25);
    // Simultaneous request and lock loss
    SW_RST_REQ = 1'b1;
    PLL_LOCKED = 1'b0;
    step(1);
    SW_RST_REQ = 1'b0;
    step(5);
    // Relock, then async reset in RELEASE
    PLL_LOCKED = 1'b1;
    step(18);
    async_reset_pulse();
    step(30);
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(1);
      if (PLL_LOCKED) PLL_LOCKED = ($urandom_range(0, 149) != 0);
      else            PLL_LOCKED = ($urandom_range(0, 3) == 0);
      if (SW_RST_REQ) SW_RST_REQ = ($urandom_range(0, 1) == 0);
      else            SW_RST_REQ = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
    end
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
